// File: rtl/vx_commit_gather.sv
`default_nettype none
// ============================================================================
// Module   : vx_commit_gather
// Purpose  : Reassembles lane-sliced commit packets (pid/sop/eop tagged) into
//            one NUM_THREADS-wide writeback per instruction.
// Revision : 1.0 - initial release
// ============================================================================
module vx_commit_gather #(
    parameter int NUM_LANES   = 4,
    parameter int NUM_THREADS = 16,
    parameter int XLEN        = 32,
    parameter int NW_WIDTH    = 2,
    parameter int UUID_WIDTH  = 44,
    parameter int PC_BITS     = 30,
    parameter int NR_BITS     = 6,
    localparam int PIDS       = NUM_THREADS / NUM_LANES,
    localparam int PID_W      = (PIDS > 1) ? $clog2(PIDS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [UUID_WIDTH-1:0]       in_uuid,
    input  logic [NW_WIDTH-1:0]         in_wid,
    input  logic [PC_BITS-1:0]          in_PC,
    input  logic [NR_BITS-1:0]          in_rd,
    input  logic                        in_wb,
    input  logic [NUM_LANES-1:0]        in_tmask,
    input  logic [PID_W-1:0]            in_pid,
    input  logic                        in_sop,
    input  logic                        in_eop,
    input  logic [NUM_LANES*XLEN-1:0]   in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [UUID_WIDTH-1:0]       out_uuid,
    output logic [NW_WIDTH-1:0]         out_wid,
    output logic [PC_BITS-1:0]          out_PC,
    output logic [NR_BITS-1:0]          out_rd,
    output logic                        out_wb,
    output logic [NUM_THREADS-1:0]      out_tmask,
    output logic [NUM_THREADS*XLEN-1:0] out_data,
    output logic                        proto_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GATHER = 2'd1,
        S_FULL   = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nx;
    logic [UUID_WIDTH-1:0]       r_uuid;
    logic [NW_WIDTH-1:0]         r_wid;
    logic [PC_BITS-1:0]          r_pc;
    logic [NR_BITS-1:0]          r_rd;
    logic                        r_wb;
    logic [NUM_THREADS-1:0]      r_tmask;
    logic [NUM_THREADS*XLEN-1:0] r_data;
    logic [PID_W-1:0]            r_last_pid;
    logic                        r_err;

    logic                        w_fire;
    logic                        w_accept;
    logic                        w_start;
    logic                        w_write;
    logic                        w_err_set;
    logic [PID_W-1:0]            w_pid;
    logic [NUM_THREADS-1:0]      w_tmask_nx;
    logic [NUM_THREADS*XLEN-1:0] w_data_nx;

    assign in_ready  = (r_state != S_FULL) || out_ready;
    assign w_fire    = (r_state == S_FULL) && out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_pid     = (PIDS > 1) ? in_pid : '0;

    assign out_valid = (r_state == S_FULL);
    assign out_uuid  = r_uuid;
    assign out_wid   = r_wid;
    assign out_PC    = r_pc;
    assign out_rd    = r_rd;
    assign out_wb    = r_wb;
    assign out_tmask = r_tmask;
    assign out_data  = r_data;
    assign proto_err = r_err;

    // Accepting a packet is only possible from IDLE, GATHER or a firing FULL,
    // so a sop always starts a new instruction; a non-sop needs GATHER.
    always_comb begin
        w_state_nx = r_state;
        w_start    = 1'b0;
        w_write    = 1'b0;
        w_err_set  = 1'b0;
        if (w_fire) begin
            w_state_nx = S_IDLE;
        end
        if (w_accept) begin
            if (in_sop) begin
                w_start    = 1'b1;
                w_write    = 1'b1;
                w_err_set  = (r_state == S_GATHER);
                w_state_nx = in_eop ? S_FULL : S_GATHER;
            end else if (r_state == S_GATHER) begin
                w_write    = 1'b1;
                w_err_set  = (in_wid != r_wid) || (in_uuid != r_uuid) ||
                             (in_pid <= r_last_pid);
                w_state_nx = in_eop ? S_FULL : S_GATHER;
            end else begin
                w_err_set  = 1'b1;
            end
        end
    end

    // Per-thread merge: the addressed slice takes the packet, others keep
    // their value or clear when a new instruction starts.
    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thread
        localparam int LANE = t % NUM_LANES;
        localparam int PID  = t / NUM_LANES;
        logic w_hit;
        assign w_hit = (w_pid == PID_W'(PID));
        assign w_tmask_nx[t] = w_hit ? in_tmask[LANE] : (!w_start && r_tmask[t]);
        assign w_data_nx[t*XLEN +: XLEN] = w_hit ? in_data[LANE*XLEN +: XLEN] :
                                           (w_start ? {XLEN{1'b0}} : r_data[t*XLEN +: XLEN]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_uuid     <= '0;
            r_wid      <= '0;
            r_pc       <= '0;
            r_rd       <= '0;
            r_wb       <= 1'b0;
            r_tmask    <= '0;
            r_data     <= '0;
            r_last_pid <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_start) begin
                r_uuid <= in_uuid;
                r_wid  <= in_wid;
                r_pc   <= in_PC;
                r_rd   <= in_rd;
                r_wb   <= in_wb;
            end
            if (w_write) begin
                r_tmask    <= w_tmask_nx;
                r_data     <= w_data_nx;
                r_last_pid <= in_pid;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vx_commit_gather.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_commit_gather
// Purpose  : Directed scoreboard bench for vx_commit_gather (16- and 4-thread).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vx_commit_gather;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int n_checks = 0;
    int n_errs   = 0;

    // 16-thread instance
    logic         in_valid, in_ready, in_wb, in_sop, in_eop;
    logic [43:0]  in_uuid, out_uuid;
    logic [1:0]   in_wid, out_wid, in_pid;
    logic [29:0]  in_pc, out_pc;
    logic [5:0]   in_rd, out_rd;
    logic [3:0]   in_tmask;
    logic [127:0] in_data;
    logic         out_valid, out_ready, out_wb, proto_err;
    logic [15:0]  out_tmask;
    logic [511:0] out_data;

    // 4-thread instance
    logic         b_in_valid, b_in_ready, b_in_sop, b_in_eop, b_in_pid;
    logic [3:0]   b_in_tmask, b_out_tmask;
    logic [127:0] b_in_data, b_out_data;
    logic         b_out_valid, b_out_ready, b_out_wb, b_proto_err;
    logic [43:0]  b_out_uuid;
    logic [1:0]   b_out_wid;
    logic [29:0]  b_out_pc;
    logic [5:0]   b_out_rd;

    vx_commit_gather u_dut (
        .clk(clk), .reset(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_uuid(in_uuid), .in_wid(in_wid),
        .in_PC(in_pc), .in_rd(in_rd), .in_wb(in_wb), .in_tmask(in_tmask), .in_pid(in_pid),
        .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_uuid(out_uuid), .out_wid(out_wid),
        .out_PC(out_pc), .out_rd(out_rd), .out_wb(out_wb), .out_tmask(out_tmask),
        .out_data(out_data), .proto_err(proto_err)
    );

    vx_commit_gather #(.NUM_LANES(4), .NUM_THREADS(4)) u_dut4 (
        .clk(clk), .reset(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_uuid(44'h7), .in_wid(2'd1),
        .in_PC(30'h100), .in_rd(6'd3), .in_wb(1'b1), .in_tmask(b_in_tmask), .in_pid(b_in_pid),
        .in_sop(b_in_sop), .in_eop(b_in_eop), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_uuid(b_out_uuid), .out_wid(b_out_wid),
        .out_PC(b_out_pc), .out_rd(b_out_rd), .out_wb(b_out_wb), .out_tmask(b_out_tmask),
        .out_data(b_out_data), .proto_err(b_proto_err)
    );

    logic [15:0]  q_tmask[$];
    logic [511:0] q_data[$];
    logic [43:0]  q_uuid[$];
    logic [3:0]   q4_tmask[$];
    logic [127:0] q4_data[$];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk(input logic [31:0] base);
        logic [127:0] r;
        for (int l = 0; l < 4; l++) r[l*32 +: 32] = base + 32'(l);
        return r;
    endfunction

    // Scoreboard monitors: pop on every writeback handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (q_tmask.size() == 0) begin
                    chk("unexpected_wb16", {495'd0, out_valid, out_tmask}, 512'd0);
                end else begin
                    chk("wb16_tmask", out_tmask, q_tmask.pop_front());
                    chk("wb16_data", out_data, q_data.pop_front());
                    chk("wb16_uuid", out_uuid, q_uuid.pop_front());
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && b_out_valid && b_out_ready) begin
                if (q4_tmask.size() == 0) begin
                    chk("unexpected_wb4", {507'd0, b_out_valid, b_out_tmask}, 512'd0);
                end else begin
                    chk("wb4_tmask", b_out_tmask, q4_tmask.pop_front());
                    chk("wb4_data", b_out_data, q4_data.pop_front());
                end
            end
        end
    end

    task automatic send(input logic sop, input logic eop, input logic [1:0] pid,
                        input logic [3:0] tm, input logic [127:0] d,
                        input logic [43:0] uuid, input logic [1:0] wid);
        int n = 0;
        in_sop = sop; in_eop = eop; in_pid = pid; in_tmask = tm; in_data = d;
        in_uuid = uuid; in_wid = wid; in_pc = 30'h2000; in_rd = 6'd5; in_wb = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin n++; @(negedge clk); end
        if (!in_ready) chk("send_timeout", 512'd0, 512'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send4(input logic [3:0] tm, input logic [127:0] d);
        int n = 0;
        b_in_sop = 1'b1; b_in_eop = 1'b1; b_in_pid = 1'b0; b_in_tmask = tm; b_in_data = d;
        b_in_valid = 1'b1;
        @(negedge clk);
        while (!b_in_ready && n < 50) begin n++; @(negedge clk); end
        if (!b_in_ready) chk("send4_timeout", 512'd0, 512'd1);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_tmask", out_tmask, 0);
        chk("rst_proto_err", proto_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] e;
        logic [511:0] held;
        rst_n = 1'b0;
        in_valid = 0; in_sop = 0; in_eop = 0; in_pid = 0; in_tmask = 0; in_data = 0;
        in_uuid = 0; in_wid = 0; in_pc = 0; in_rd = 0; in_wb = 0; out_ready = 1'b1;
        b_in_valid = 0; b_in_sop = 0; b_in_eop = 0; b_in_pid = 0; b_in_tmask = 0;
        b_in_data = 0; b_out_ready = 1'b1;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_proto_err", proto_err, 0);
        chk("reset_tmask", out_tmask, 0);
        chk("reset_data", out_data, 0);
        chk("reset_uuid", out_uuid, 0);
        chk("reset_in_ready", in_ready, 1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: full instruction, data[t] = t
        for (int t = 0; t < 16; t++) e[t*32 +: 32] = 32'(t);
        q_tmask.push_back(16'hFFFF); q_data.push_back(e); q_uuid.push_back(44'h11);
        send(1, 0, 2'd0, 4'hF, mk(32'd0),  44'h11, 2'd1);
        send(0, 0, 2'd1, 4'hF, mk(32'd4),  44'h11, 2'd1);
        send(0, 0, 2'd2, 4'hF, mk(32'd8),  44'h11, 2'd1);
        chk("t1_no_early_valid", out_valid, 0);
        send(0, 1, 2'd3, 4'hF, mk(32'd12), 44'h11, 2'd1);
        chk("t1_valid_after_eop", out_valid, 1);
        chk("t1_proto_err", proto_err, 0);
        @(posedge clk); #1;
        chk("t1_single_wb", out_valid, 0);

        // 2: sparse slices
        e = '0;
        e[0 +: 128]   = mk(32'hA000);
        e[256 +: 128] = mk(32'hB000);
        q_tmask.push_back(16'h0801); q_data.push_back(e); q_uuid.push_back(44'h22);
        send(1, 0, 2'd0, 4'h1, mk(32'hA000), 44'h22, 2'd2);
        send(0, 1, 2'd2, 4'h8, mk(32'hB000), 44'h22, 2'd2);
        @(posedge clk); #1;

        // 3: backpressure then fire with back-to-back sop
        out_ready = 1'b0;
        e = '0;
        for (int p = 0; p < 4; p++) e[p*128 +: 128] = mk(32'h300 + 32'(p*16));
        q_tmask.push_back(16'hFFFF); q_data.push_back(e); q_uuid.push_back(44'h33);
        for (int p = 0; p < 4; p++)
            send(p == 0, p == 3, 2'(p), 4'hF, mk(32'h300 + 32'(p*16)), 44'h33, 2'd0);
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_in_ready_low", in_ready, 0);
            chk("t3_valid_held", out_valid, 1);
            chk("t3_data_stable", out_data, held);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        e = '0;
        e[0 +: 128] = mk(32'h400);
        q_tmask.push_back(16'h000F); q_data.push_back(e); q_uuid.push_back(44'h34);
        send(1, 1, 2'd0, 4'hF, mk(32'h400), 44'h34, 2'd0);
        chk("t3_no_gap_valid", out_valid, 1);
        chk("t3_no_gap_uuid", out_uuid, 44'h34);
        @(posedge clk); #1;

        // 4: single-slice configuration, three back-to-back
        q4_tmask.push_back(4'hF); q4_data.push_back(mk(32'h500));
        q4_tmask.push_back(4'h5); q4_data.push_back(mk(32'h600));
        q4_tmask.push_back(4'hA); q4_data.push_back(mk(32'h700));
        send4(4'hF, mk(32'h500));
        chk("t4_valid_1", b_out_valid, 1);
        send4(4'h5, mk(32'h600));
        chk("t4_valid_2", b_out_valid, 1);
        send4(4'hA, mk(32'h700));
        chk("t4_valid_3", b_out_valid, 1);
        @(posedge clk); #1;
        chk("t4_drained", b_out_valid, 0);
        chk("t4_proto_err", b_proto_err, 0);

        // 5: protocol violations
        chk("t5_err_before", proto_err, 0);
        send(0, 0, 2'd1, 4'hF, mk(32'h800), 44'h55, 2'd1);
        chk("t5_idle_nonsop_err", proto_err, 1);
        chk("t5_idle_nonsop_drop", out_valid, 0);
        @(posedge clk); #1;
        chk("t5_still_no_valid", out_valid, 0);
        pulse_reset();
        chk("t5_err_cleared", proto_err, 0);
        e = '0;
        e[0 +: 128]   = mk(32'h920);
        e[128 +: 128] = mk(32'h940);
        q_tmask.push_back(16'h00F3); q_data.push_back(e); q_uuid.push_back(44'h56);
        send(1, 0, 2'd0, 4'hF, mk(32'h900), 44'h56, 2'd1);
        chk("t5_clean_sop", proto_err, 0);
        send(0, 0, 2'd0, 4'h3, mk(32'h920), 44'h56, 2'd1);
        chk("t5_pid_repeat_err", proto_err, 1);
        send(0, 1, 2'd1, 4'hF, mk(32'h940), 44'h56, 2'd1);
        @(posedge clk); #1;

        // 6: reset mid-GATHER and mid-FULL
        send(1, 0, 2'd0, 4'hF, mk(32'hA00), 44'h66, 2'd3);
        send(0, 0, 2'd1, 4'hF, mk(32'hA10), 44'h66, 2'd3);
        pulse_reset();
        e = '0;
        for (int p = 0; p < 4; p++) e[p*128 +: 128] = mk(32'hC00 + 32'(p*16));
        q_tmask.push_back(16'hFFFF); q_data.push_back(e); q_uuid.push_back(44'h67);
        for (int p = 0; p < 4; p++)
            send(p == 0, p == 3, 2'(p), 4'hF, mk(32'hC00 + 32'(p*16)), 44'h67, 2'd3);
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(1, 1, 2'd0, 4'hF, mk(32'hD00), 44'h68, 2'd3);
        chk("t6_full_valid", out_valid, 1);
        pulse_reset();
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t6_no_wb_after_reset", out_valid, 0);
        @(posedge clk); #1;

        chk("sb16_empty", 512'(q_tmask.size()), 0);
        chk("sb4_empty", 512'(q4_tmask.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
